// File: rtl/ramdisk_sram_pkg.sv
// Shared types for the RAM-disk SRAM arbiter.
// Holds the FSM state encoding, owner codes and the SRAM address width.
package ramdisk_sram_pkg;

  localparam int SRAM_AW = 19;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_LDR = 2'd1,
    OWN_CPU = 2'd2
  } owner_e;

endpackage

// File: rtl/ramdisk_sram_arbiter_if.sv
// Requester and SRAM pin bundle for the RAM-disk SRAM arbiter.
// master: requesters + SRAM data-in side; slave: the arbiter itself.
interface ramdisk_sram_arbiter_if;
  import ramdisk_sram_pkg::*;

  logic               vid_req;
  logic [15:0]        vid_addr;
  logic [7:0]         vid_rdata;
  logic               vid_ack;

  logic               ldr_req;
  logic [SRAM_AW-1:0] ldr_addr;
  logic [7:0]         ldr_wdata;
  logic               ldr_ack;

  logic               cpu_req;
  logic               cpu_we;
  logic [2:0]         cpu_page;
  logic [15:0]        cpu_addr;
  logic [7:0]         cpu_wdata;
  logic [7:0]         cpu_rdata;
  logic               cpu_ack;

  logic [SRAM_AW-1:0] sram_addr;
  logic [7:0]         sram_dq_o;
  logic [7:0]         sram_dq_i;
  logic               sram_dq_oe;
  logic               sram_oe_n;
  logic               sram_we_n;

  modport master (
    output vid_req, vid_addr,
    output ldr_req, ldr_addr, ldr_wdata,
    output cpu_req, cpu_we, cpu_page,
    output cpu_addr, cpu_wdata,
    output sram_dq_i,
    input  vid_rdata, vid_ack, ldr_ack,
    input  cpu_rdata, cpu_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_oe_n, sram_we_n
  );

  modport slave (
    input  vid_req, vid_addr,
    input  ldr_req, ldr_addr, ldr_wdata,
    input  cpu_req, cpu_we, cpu_page,
    input  cpu_addr, cpu_wdata,
    input  sram_dq_i,
    output vid_rdata, vid_ack, ldr_ack,
    output cpu_rdata, cpu_ack,
    output sram_addr, sram_dq_o, sram_dq_oe,
    output sram_oe_n, sram_we_n
  );

endinterface

// File: rtl/ramdisk_sram_arbiter.sv
// Shares one async 512Kx8 SRAM between video, loader and CPU.
// Ports: clk, reset_n (async low), bus (requesters + SRAM pins).
module ramdisk_sram_arbiter
  import ramdisk_sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int CPU_MAX_SKIP  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ramdisk_sram_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] SKIP_MAX = 4'(CPU_MAX_SKIP);

  state_e             state_q, state_d;
  owner_e             owner_q, grant;
  logic [3:0]         cnt_q, skip_q;
  logic               we_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [7:0]         wdata_q;
  logic [7:0]         vid_rdata_q, cpu_rdata_q;
  logic               any_req, force_cpu;
  logic               g_vid, g_ldr, g_cpu;
  logic               start, last;

  assign any_req   = bus.vid_req | bus.ldr_req | bus.cpu_req;
  assign force_cpu = bus.cpu_req & (skip_q >= SKIP_MAX);

  // One-hot grant: starvation override first, else vid > ldr > cpu.
  assign g_vid = bus.vid_req & ~force_cpu;
  assign g_ldr = bus.ldr_req & ~bus.vid_req & ~force_cpu;
  assign g_cpu = force_cpu
               | (bus.cpu_req & ~bus.vid_req & ~bus.ldr_req);

  assign start = (state_q == ST_IDLE) & any_req;
  assign last  = (state_q == ST_ACCESS) & (cnt_q == 4'd0);

  always_comb begin
    grant = OWN_VID;
    unique case (1'b1)
      g_vid:   grant = OWN_VID;
      g_ldr:   grant = OWN_LDR;
      g_cpu:   grant = OWN_CPU;
      default: grant = OWN_VID;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 4'd0;
      skip_q      <= 4'd0;
      owner_q     <= OWN_VID;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      vid_rdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      if (start) begin
        owner_q <= grant;
        cnt_q   <= CNT_LOAD;
        unique case (1'b1)
          g_cpu: begin
            addr_q  <= {bus.cpu_page, bus.cpu_addr};
            wdata_q <= bus.cpu_wdata;
            we_q    <= bus.cpu_we;
          end
          g_ldr: begin
            addr_q  <= bus.ldr_addr;
            wdata_q <= bus.ldr_wdata;
            we_q    <= 1'b1;
          end
          default: begin
            addr_q <= {3'b000, bus.vid_addr};
            we_q   <= 1'b0;
          end
        endcase
        // Only grants that make a waiting CPU lose count as skips.
        if (g_cpu)
          skip_q <= 4'd0;
        else if (bus.cpu_req && skip_q != 4'hF)
          skip_q <= skip_q + 4'd1;
      end
      if (state_q == ST_ACCESS && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      if (last && !we_q) begin
        if (owner_q == OWN_VID) vid_rdata_q <= bus.sram_dq_i;
        if (owner_q == OWN_CPU) cpu_rdata_q <= bus.sram_dq_i;
      end
    end
  end

  // DONE keeps dq driven for write hold / bus turnaround.
  always_comb begin
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_dq_oe = 1'b0;
    bus.vid_ack    = 1'b0;
    bus.ldr_ack    = 1'b0;
    bus.cpu_ack    = 1'b0;
    unique case (state_q)
      ST_ACCESS: begin
        bus.sram_oe_n  = we_q;
        bus.sram_we_n  = ~we_q;
        bus.sram_dq_oe = we_q;
      end
      ST_DONE: begin
        bus.sram_dq_oe = we_q;
        bus.vid_ack    = (owner_q == OWN_VID);
        bus.ldr_ack    = (owner_q == OWN_LDR);
        bus.cpu_ack    = (owner_q == OWN_CPU);
      end
      default: ;
    endcase
  end

  assign bus.sram_addr = addr_q;
  assign bus.sram_dq_o = wdata_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_ramdisk_sram_arbiter.sv
// Self-checking bench for ramdisk_sram_arbiter.
// Directed scenarios plus a randomized run against a transaction model.
module tb_ramdisk_sram_arbiter;
  import ramdisk_sram_pkg::*;

  localparam int AC = 2;
  localparam int MS = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ramdisk_sram_arbiter_if bus();

  ramdisk_sram_arbiter #(
    .ACCESS_CYCLES(AC),
    .CPU_MAX_SKIP(MS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  sram_mem [0:524287];
  logic [7:0]  ref_mem  [0:524287];
  bit          mem_init;
  logic        bd_en = 1'b0;
  logic [18:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  function automatic logic [7:0] pat(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b10100, a[18:16]};
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 524288; i++) sram_mem[i] <= pat(19'(i));
      mem_init <= 1'b1;
    end else if (bd_en) begin
      sram_mem[bd_addr] <= bd_data;
    end else if (!bus.sram_we_n && bus.sram_dq_oe) begin
      sram_mem[bus.sram_addr] <= bus.sram_dq_o;
    end
  end

  assign bus.sram_dq_i = bus.sram_oe_n ? 8'h00 : sram_mem[bus.sram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.ldr_req = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_page = '0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe} !== 3'b110) begin
      errors++;
      $display("FAIL reset_strobes: got %b exp 110",
        {bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe});
    end
    checks++;
    if (bus.sram_addr !== 19'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h exp 0", bus.sram_addr);
    end
    checks++;
    if (bus.sram_dq_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_dq_o: got %h exp 0", bus.sram_dq_o);
    end
    checks++;
    if ({bus.vid_rdata, bus.cpu_rdata} !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h exp 0",
        {bus.vid_rdata, bus.cpu_rdata});
    end
    checks++;
    if ({bus.vid_ack, bus.ldr_ack, bus.cpu_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_acks: got %b exp 000",
        {bus.vid_ack, bus.ldr_ack, bus.cpu_ack});
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset_mid_write();
    bit seen = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_page = 3'd2;
    bus.cpu_addr = 16'hA123; bus.cpu_wdata = 8'h55;
    tick();
    checks++;
    if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== 19'h2A123) begin
      errors++;
      $display("FAIL rmw_access: we_n %b addr %h exp 0 2a123",
        bus.sram_we_n, bus.sram_addr);
    end
    reset_n = 0;
    #1;
    checks++;
    if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL rmw_async: we_n %b dq_oe %b exp 1 0",
        bus.sram_we_n, bus.sram_dq_oe);
    end
    bus.cpu_req = 0;
    tick();
    reset_n = 1;
    repeat (6) begin
      tick();
      if (bus.cpu_ack) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rmw_no_ack: got cpu_ack after reset");
    end
    bus.vid_req = 1; bus.vid_addr = 16'h0010;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (bus.vid_ack !== (t == 3)) begin
        errors++;
        $display("FAIL rmw_idle_ack t%0d: got %b exp %b",
          t, bus.vid_ack, (t == 3));
      end
      if (t == 3) begin
        bus.vid_req = 0;
        checks++;
        if (bus.vid_rdata !== pat(19'h00010)) begin
          errors++;
          $display("FAIL rmw_idle_rd: got %h exp %h",
            bus.vid_rdata, pat(19'h00010));
        end
      end
    end
  endtask

  task automatic test_cpu_read();
    bd_addr = 19'h3B000; bd_data = 8'h5A; bd_en = 1;
    tick();
    bd_en = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_page = 3'd3;
    bus.cpu_addr = 16'hB000;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (bus.cpu_ack !== (t == 3)) begin
        errors++;
        $display("FAIL cpurd_ack t%0d: got %b exp %b",
          t, bus.cpu_ack, (t == 3));
      end
      if (t == 1) begin
        checks++;
        if (bus.sram_addr !== 19'h3B000 || bus.sram_oe_n !== 1'b0) begin
          errors++;
          $display("FAIL cpurd_addr: addr %h oe_n %b exp 3b000 0",
            bus.sram_addr, bus.sram_oe_n);
        end
      end
      if (t == 3) begin
        bus.cpu_req = 0;
        checks++;
        if (bus.cpu_rdata !== 8'h5A) begin
          errors++;
          $display("FAIL cpurd_data: got %h exp 5a", bus.cpu_rdata);
        end
      end
    end
  endtask

  task automatic test_ldr_write();
    bus.ldr_req = 1; bus.ldr_addr = 19'h7FFFF; bus.ldr_wdata = 8'hC3;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (bus.ldr_ack !== (t == 3)) begin
        errors++;
        $display("FAIL ldr_ack t%0d: got %b exp %b",
          t, bus.ldr_ack, (t == 3));
      end
      if (t <= 3) begin
        checks++;
        if (bus.sram_we_n !== (t == 3) || bus.sram_dq_oe !== 1'b1 ||
            bus.sram_dq_o !== 8'hC3 || bus.sram_addr !== 19'h7FFFF) begin
          errors++;
          $display("FAIL ldr_bus t%0d: we_n %b oe %b dq %h addr %h",
            t, bus.sram_we_n, bus.sram_dq_oe,
            bus.sram_dq_o, bus.sram_addr);
        end
      end
      if (t == 3) bus.ldr_req = 0;
    end
    checks++;
    if (bus.sram_dq_oe !== 1'b0 || sram_mem[19'h7FFFF] !== 8'hC3) begin
      errors++;
      $display("FAIL ldr_mem: dq_oe %b mem %h exp 0 c3",
        bus.sram_dq_oe, sram_mem[19'h7FFFF]);
    end
  endtask

  task automatic test_simultaneous();
    int at[3] = '{-1, -1, -1};
    int n[3]  = '{0, 0, 0};
    bus.vid_req = 1; bus.vid_addr = 16'h0042;
    bus.ldr_req = 1; bus.ldr_addr = 19'h12345; bus.ldr_wdata = 8'h9E;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_page = 3'd1;
    bus.cpu_addr = 16'h1234;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (bus.vid_ack) begin at[0] = t; n[0]++; bus.vid_req = 0; end
      if (bus.ldr_ack) begin at[1] = t; n[1]++; bus.ldr_req = 0; end
      if (bus.cpu_ack) begin at[2] = t; n[2]++; bus.cpu_req = 0; end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (at[i] !== 3 + 4 * i || n[i] !== 1) begin
        errors++;
        $display("FAIL simul_ack%0d: at %0d count %0d exp %0d 1",
          i, at[i], n[i], 3 + 4 * i);
      end
    end
    checks++;
    if (bus.vid_rdata !== pat(19'h00042) ||
        bus.cpu_rdata !== pat(19'h11234)) begin
      errors++;
      $display("FAIL simul_rd: vid %h cpu %h exp %h %h",
        bus.vid_rdata, bus.cpu_rdata,
        pat(19'h00042), pat(19'h11234));
    end
  endtask

  task automatic test_starvation();
    int seq[8];
    int exp_seq[8] = '{0, 0, 0, 2, 0, 0, 0, 2};
    int n = 0;
    bus.vid_req = 1; bus.vid_addr = 16'h0100;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_page = 3'd0;
    bus.cpu_addr = 16'h0200;
    for (int t = 1; t <= 40 && n < 8; t++) begin
      tick();
      if (bus.vid_ack) begin seq[n] = 0; n++; end
      else if (bus.cpu_ack) begin seq[n] = 2; n++; end
    end
    bus.vid_req = 0;
    bus.cpu_req = 0;
    tick();
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL starve_count: got %0d acks exp 8", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL starve_order%0d: got owner %0d exp %0d",
          i, seq[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a[3];
    int n = 0;
    bus.vid_req = 1; bus.vid_addr = 16'h0300;
    for (int t = 1; t <= 20 && n < 3; t++) begin
      tick();
      if (n >= 1 && t == a[0] + 1) begin
        checks++;
        if (bus.sram_oe_n !== 1'b1) begin
          errors++;
          $display("FAIL b2b_idle: oe_n %b exp 1", bus.sram_oe_n);
        end
      end
      if (n >= 1 && t == a[0] + 2) begin
        checks++;
        if (bus.sram_oe_n !== 1'b0) begin
          errors++;
          $display("FAIL b2b_restart: oe_n %b exp 0", bus.sram_oe_n);
        end
      end
      if (bus.vid_ack) begin a[n] = t; n++; end
    end
    bus.vid_req = 0;
    tick();
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks exp 3", n);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (a[i] - a[i-1] !== AC + 2) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d exp %0d",
            i, a[i] - a[i-1], AC + 2);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          busy = 0;
    int          g_cyc = 0;
    int          own = 0;
    int          skip = 0;
    logic [18:0] e_addr = '0;
    logic        e_we = 0;
    logic [7:0]  e_data = '0;
    logic [7:0]  e_rd = '0;
    logic [2:0]  got, exp_ack;
    for (int i = 0; i < 524288; i++) ref_mem[i] = pat(19'(i));
    for (int i = 0; i < 830; i++) begin
      tick();
      if (busy && cyc >= g_cyc + AC + 2) busy = 0;
      if (!busy && (bus.vid_req || bus.ldr_req || bus.cpu_req)) begin
        if (bus.cpu_req && skip >= MS) own = 2;
        else if (bus.vid_req)          own = 0;
        else if (bus.ldr_req)          own = 1;
        else                           own = 2;
        if (own == 2) skip = 0;
        else if (bus.cpu_req && skip < 15) skip++;
        case (own)
          0: begin e_addr = {3'b000, bus.vid_addr}; e_we = 0; end
          1: begin
            e_addr = bus.ldr_addr; e_we = 1; e_data = bus.ldr_wdata;
          end
          default: begin
            e_addr = {bus.cpu_page, bus.cpu_addr};
            e_we = bus.cpu_we; e_data = bus.cpu_wdata;
          end
        endcase
        if (e_we) ref_mem[e_addr] = e_data;
        else      e_rd = ref_mem[e_addr];
        busy = 1;
        g_cyc = cyc;
      end
      got = {bus.cpu_ack, bus.ldr_ack, bus.vid_ack};
      exp_ack = (busy && cyc == g_cyc + AC) ? 3'(1 << own) : 3'b000;
      checks++;
      if (got !== exp_ack) begin
        errors++;
        $display("FAIL rnd_ack cyc %0d: got %b exp %b",
          cyc, got, exp_ack);
      end
      if (busy && cyc == g_cyc) begin
        checks++;
        if (bus.sram_addr !== e_addr || bus.sram_oe_n !== e_we ||
            bus.sram_we_n !== !e_we ||
            (e_we && bus.sram_dq_o !== e_data)) begin
          errors++;
          $display("FAIL rnd_bus cyc %0d: addr %h oe_n %b we_n %b exp %h we %b",
            cyc, bus.sram_addr, bus.sram_oe_n, bus.sram_we_n,
            e_addr, e_we);
        end
      end
      if (busy && cyc == g_cyc + AC && !e_we) begin
        checks++;
        if ((own == 0 ? bus.vid_rdata : bus.cpu_rdata) !== e_rd) begin
          errors++;
          $display("FAIL rnd_rdata cyc %0d owner %0d: got %h exp %h",
            cyc, own,
            (own == 0 ? bus.vid_rdata : bus.cpu_rdata), e_rd);
        end
      end
      if (got[0]) bus.vid_req = 0;
      else if (i < 800 && !bus.vid_req && $urandom_range(0, 2) == 0) begin
        bus.vid_addr = {12'hC00, 4'($urandom)};
        bus.vid_req = 1;
      end
      if (got[1]) bus.ldr_req = 0;
      else if (i < 800 && !bus.ldr_req && $urandom_range(0, 2) == 0) begin
        bus.ldr_addr = {3'($urandom), 12'hC00, 4'($urandom)};
        bus.ldr_wdata = 8'($urandom);
        bus.ldr_req = 1;
      end
      if (got[2]) bus.cpu_req = 0;
      else if (i < 800 && !bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_we = 1'($urandom);
        bus.cpu_page = 3'($urandom);
        bus.cpu_addr = {12'hC00, 4'($urandom)};
        bus.cpu_wdata = 8'($urandom);
        bus.cpu_req = 1;
      end
    end
    checks++;
    if ({bus.vid_req, bus.ldr_req, bus.cpu_req} !== 3'b000) begin
      errors++;
      $display("FAIL rnd_drain: reqs still waiting %b exp 000",
        {bus.vid_req, bus.ldr_req, bus.cpu_req});
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_cpu_read();
    test_ldr_write();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
